// File: rtl/mux_channel_scheduler_if.sv
// Request/grant bundle between the requesters and the channel-mux scheduler.
// The scheduler uses the master view; requesters use the slave view.
interface mux_channel_scheduler_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int SEL_WIDTH    = 2
);
  logic [NUM_CHANNELS-1:0] request;
  logic [NUM_CHANNELS-1:0] grant;
  logic [SEL_WIDTH-1:0]    selection_output;
  logic                    output_enable;
  logic                    busy;

  modport master (
    input  request,
    output grant,
    output selection_output,
    output output_enable,
    output busy
  );

  modport slave (
    output request,
    input  grant,
    input  selection_output,
    input  output_enable,
    input  busy
  );
endinterface

// File: rtl/mux_channel_scheduler.sv
// Round-robin owner of a shared N-input channel mux, with a break-before-make
// guard on every select change and a dwell limit so one requester cannot starve the rest.
module mux_channel_scheduler #(
  parameter int NUM_CHANNELS = 4,
  parameter int SEL_WIDTH    = 2,
  parameter int GUARD_CYCLES = 1,
  parameter int MAX_DWELL    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  mux_channel_scheduler_if.master bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GUARD   = 2'd1;
  localparam logic [1:0] ST_GRANTED = 2'd2;

  localparam int                   CHW        = SEL_WIDTH + 1;
  localparam logic [CHW-1:0]       NUM_CH_W   = CHW'(NUM_CHANNELS);
  localparam logic [SEL_WIDTH-1:0] LAST_RESET = SEL_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [3:0]           GUARD_LAST = 4'(GUARD_CYCLES - 1);
  localparam logic [7:0]           DWELL_MAX  = 8'(MAX_DWELL);

  logic [1:0]              r_state;
  logic [NUM_CHANNELS-1:0] r_grant;
  logic [SEL_WIDTH-1:0]    r_sel;
  logic [SEL_WIDTH-1:0]    r_last;
  logic                    r_oe;
  logic                    r_busy;
  logic [7:0]              r_dwell;
  logic [3:0]              r_guard;

  logic                    w_anyReq;
  logic                    w_ownerReq;
  logic                    w_otherReq;
  logic [NUM_CHANNELS-1:0] w_ownerMask;
  logic [7:0]              w_dwellNext;
  logic [SEL_WIDTH-1:0]    w_winner;
  logic                    w_found;
  logic [CHW-1:0]          w_sum;

  assign w_anyReq    = |bus.request;
  assign w_ownerMask = NUM_CHANNELS'(1) << r_sel;
  assign w_ownerReq  = |(bus.request & w_ownerMask);
  assign w_otherReq  = |(bus.request & ~w_ownerMask);

  // Preemption looks at the count including the current grant cycle, so the
  // owner keeps the mux for exactly MAX_DWELL cycles before it can be bumped.
  assign w_dwellNext = (r_dwell == DWELL_MAX) ? DWELL_MAX : r_dwell + 8'd1;

  always_comb begin
    w_winner = r_last;
    w_found  = 1'b0;
    w_sum    = '0;
    for (int i = 1; i <= NUM_CHANNELS; i++) begin
      w_sum = {1'b0, r_last} + CHW'(i);
      if (w_sum >= NUM_CH_W) begin
        w_sum = w_sum - NUM_CH_W;
      end
      if (!w_found && bus.request[w_sum[SEL_WIDTH-1:0]]) begin
        w_winner = w_sum[SEL_WIDTH-1:0];
        w_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_last  <= LAST_RESET;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
      r_dwell <= '0;
      r_guard <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_anyReq) begin
            r_sel   <= w_winner;
            r_last  <= w_winner;
            r_guard <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_GUARD;
          end
        end

        ST_GUARD: begin
          if (!w_ownerReq) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_guard == GUARD_LAST) begin
            r_grant <= w_ownerMask;
            r_oe    <= 1'b1;
            r_dwell <= '0;
            r_state <= ST_GRANTED;
          end else begin
            r_guard <= r_guard + 4'd1;
          end
        end

        // Release and preemption share one exit; the pointer already names the owner.
        ST_GRANTED: begin
          if (!w_ownerReq || ((w_dwellNext == DWELL_MAX) && w_otherReq)) begin
            r_grant <= '0;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_dwell <= w_dwellNext;
          end
        end

        default: begin
          r_grant <= '0;
          r_oe    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grant            = r_grant;
  assign bus.selection_output = r_sel;
  assign bus.output_enable    = r_oe;
  assign bus.busy             = r_busy;

endmodule

// File: tb/tb_mux_channel_scheduler.sv
// Directed bench for mux_channel_scheduler with 4 channels, 1 guard cycle, dwell limit 4.
module tb_mux_channel_scheduler;

  localparam int NUM_CHANNELS = 4;
  localparam int SEL_WIDTH    = 2;
  localparam int GUARD_CYCLES = 1;
  localparam int MAX_DWELL    = 4;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  mux_channel_scheduler_if #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .SEL_WIDTH   (SEL_WIDTH)
  ) bus ();

  mux_channel_scheduler #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .SEL_WIDTH   (SEL_WIDTH),
    .GUARD_CYCLES(GUARD_CYCLES),
    .MAX_DWELL   (MAX_DWELL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] req);
    bus.request = req;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expGrant,
                             input logic [1:0] expSel, input logic expOe,
                             input logic expBusy);
    compared++;
    assert ({bus.grant, bus.selection_output, bus.output_enable, bus.busy} ===
            {expGrant, expSel, expOe, expBusy})
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed grant=%b sel=%0d oe=%b busy=%b, expected grant=%b sel=%0d oe=%b busy=%b",
             tag, bus.grant, bus.selection_output, bus.output_enable, bus.busy,
             expGrant, expSel, expOe, expBusy);
    end
  endtask

  initial begin
    int         ch;
    logic [3:0] req;

    // Reset then idle
    reset = 1'b1;
    applyStimulus(4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("reset_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    tick();
    checkOutput("idle_no_req", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single request on channel 2
    applyStimulus(4'b0100);
    tick();
    checkOutput("single_guard", 4'b0000, 2'd2, 1'b0, 1'b1);
    tick();
    checkOutput("single_grant", 4'b0100, 2'd2, 1'b1, 1'b1);
    tick();
    checkOutput("single_hold", 4'b0100, 2'd2, 1'b1, 1'b1);
    applyStimulus(4'b0000);
    tick();
    checkOutput("single_release", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();
    checkOutput("idle_sel_holds", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Fresh reset so round-robin starts at channel 0
    reset = 1'b1;
    tick();
    checkOutput("reset_again", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // Round-robin fairness: all request, each owner releases after 2 grant cycles
    applyStimulus(4'b1111);
    for (int k = 0; k < 5; k++) begin
      ch = k % 4;
      tick();
      checkOutput("rr_guard", 4'b0000, 2'(ch), 1'b0, 1'b1);
      tick();
      checkOutput("rr_grant1", 4'(1 << ch), 2'(ch), 1'b1, 1'b1);
      tick();
      checkOutput("rr_grant2", 4'(1 << ch), 2'(ch), 1'b1, 1'b1);
      req = 4'b1111;
      req[ch] = 1'b0;
      applyStimulus(req);
      tick();
      checkOutput("rr_release", 4'b0000, 2'(ch), 1'b0, 1'b0);
      applyStimulus((k == 4) ? 4'b0000 : 4'b1111);
    end

    // Dwell preemption: channel 1 owns, channel 3 arrives
    applyStimulus(4'b0010);
    tick();
    checkOutput("dwell_guard1", 4'b0000, 2'd1, 1'b0, 1'b1);
    tick();
    checkOutput("dwell_grant_c1", 4'b0010, 2'd1, 1'b1, 1'b1);
    applyStimulus(4'b1010);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("dwell_before_limit", 4'b0010, 2'd1, 1'b1, 1'b1);
    end
    tick();
    checkOutput("dwell_preempt", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();
    checkOutput("dwell_guard3", 4'b0000, 2'd3, 1'b0, 1'b1);
    tick();
    checkOutput("dwell_grant_c3", 4'b1000, 2'd3, 1'b1, 1'b1);

    // Channel 3 leaves; channel 1 then holds far past the dwell limit
    applyStimulus(4'b0010);
    tick();
    checkOutput("c3_release", 4'b0000, 2'd3, 1'b0, 1'b0);
    tick();
    checkOutput("c1_guard_again", 4'b0000, 2'd1, 1'b0, 1'b1);
    for (int i = 0; i < 23; i++) begin
      tick();
      checkOutput("c1_long_hold", 4'b0010, 2'd1, 1'b1, 1'b1);
    end
    // Saturated dwell: a new competitor preempts at the very next edge
    applyStimulus(4'b1010);
    tick();
    checkOutput("saturated_preempt", 4'b0000, 2'd1, 1'b0, 1'b0);
    applyStimulus(4'b0000);
    tick();
    checkOutput("idle_after_preempt", 4'b0000, 2'd1, 1'b0, 1'b0);

    // Guard abort: channel 2 pulses for one cycle
    applyStimulus(4'b0100);
    tick();
    checkOutput("abort_guard", 4'b0000, 2'd2, 1'b0, 1'b1);
    applyStimulus(4'b0000);
    tick();
    checkOutput("abort_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();
    checkOutput("abort_no_grant", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Reset mid-grant, then channel 0 wins from the reset pointer
    applyStimulus(4'b0010);
    tick();
    checkOutput("mid_guard", 4'b0000, 2'd1, 1'b0, 1'b1);
    tick();
    checkOutput("mid_grant", 4'b0010, 2'd1, 1'b1, 1'b1);
    reset = 1'b1;
    tick();
    checkOutput("mid_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b0011);
    reset = 1'b0;
    tick();
    checkOutput("post_reset_guard", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("post_reset_grant", 4'b0001, 2'd0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux_channel_scheduler.md
# mux_channel_scheduler

Round-robin scheduler that shares one N-input channel mux between N requesters. It arbitrates level-sensitive requests and drives the mux select lines. It also inserts a break-before-make guard interval on every channel change and enforces a maximum dwell time, so a persistent requester cannot starve the others. It sits directly in front of the board-level channel mux and owns its selection input; downstream logic qualifies mux data with `output_enable`.

## Interface

Parameters:
- `NUM_CHANNELS`, default 4: number of requesters and mux channels; legal range 2..8.
- `SEL_WIDTH`, default 2: width of the select bus; must equal ceil(log2(NUM_CHANNELS)).
- `GUARD_CYCLES`, default 1: cycles with output disabled after the select changes, before the grant; legal range 1..15.
- `MAX_DWELL`, default 16: grant cycles after which the owner can be preempted; legal range 2..255.

Ports:
- `clk`, input, 1: single system clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `request`, input, NUM_CHANNELS: bit i high means channel i wants the mux; level-sensitive, held until the channel is done.
- `grant`, output, NUM_CHANNELS: one-hot or zero; bit i high means channel i owns the mux output.
- `selection_output`, output, SEL_WIDTH: binary mux select (channel index).
- `output_enable`, output, 1: high only while a grant is active; mux output is valid.
- `busy`, output, 1: high in GUARD and GRANTED states.

## Operation

- All outputs are registered.
- Reset values:
  - state = IDLE
  - grant = 0
  - selection_output = 0
  - output_enable = 0
  - busy = 0
  - dwell counter = 0
  - guard counter = 0
  - last-granted pointer = NUM_CHANNELS-1, so channel 0 has first priority.
- Arbitration: scan from last_granted+1 upward, wrapping modulo NUM_CHANNELS. The first channel with request high wins.
- States:
  - IDLE: grant = 0, output_enable = 0; selection_output holds its last value, so there are no select glitches. If any request is high, load the winner into selection_output and last_granted, clear the guard counter, and go to GUARD. Otherwise stay in IDLE.
  - GUARD: grant = 0, output_enable = 0, busy = 1.
    - If request[selection_output] drops, go to IDLE (abort).
    - Otherwise count; after GUARD_CYCLES cycles in GUARD, go to GRANTED and clear the dwell counter.
  - GRANTED: grant[selection_output] = 1, output_enable = 1, busy = 1. The dwell counter increments each cycle and saturates at MAX_DWELL.
    - Release: if request[selection_output] is low, go to IDLE.
    - Preempt: if dwell counter == MAX_DWELL and any other request bit is high, go to IDLE. The pointer already points at the owner, so the next scan starts after it.
    - If dwell has expired but no other channel requests, the owner keeps the grant indefinitely.
- Simultaneous release and preemption in the same cycle: treated as a release; the result is the same IDLE transition.
- At most one grant bit is ever high. Grant is never high in the same cycle that selection_output changes.
- A request dropping in IDLE has no effect.
- A request bit dropping for a non-owner while GUARD or GRANTED is active has no effect.
- Reset asserted in any state: all outputs reach their reset values at that clock edge, and any grant is lost immediately.

## Timing

- Request-to-grant latency from IDLE is 1 + GUARD_CYCLES edges:
  - request rises before edge E;
  - selection_output is valid after E;
  - grant and output_enable rise after E + GUARD_CYCLES.
- Release latency: owner request low before edge E means grant and output_enable are low after E.
- Channel switch: one IDLE cycle plus GUARD_CYCLES between grants. With defaults, grants are separated by at least 2 zero-grant cycles.
- Preemption happens at the first edge where the dwell counter equals MAX_DWELL, i.e. after MAX_DWELL grant cycles.

## Test plan

All scenarios use NUM_CHANNELS = 4, GUARD_CYCLES = 1, MAX_DWELL = 4.

- Reset then idle: `reset` held 3 cycles, request = 0 -> grant = 0, selection_output = 0, output_enable = 0, busy = 0 throughout.
- Single request: request = 4'b0100 from cycle 10 -> selection_output = 2 after edge 11; grant = 4'b0100 and output_enable = 1 after edge 12. Dropping request -> grant = 0 at the next edge.
- Round-robin fairness: request = 4'b1111 held, each owner releasing after 2 grant cycles -> grant order 0, 1, 2, 3, 0, with 2 zero-grant cycles between grants.
- Dwell preemption: channel 1 is granted and holds its request, then channel 3 requests -> channel 1 loses grant after exactly 4 grant cycles; channel 3 is granted 2 cycles later. With channel 3 idle, channel 1 holds grant for over 20 cycles.
- Guard abort: channel 2 request pulses for 1 cycle -> GUARD entered, selection_output = 2, return to IDLE, grant never asserted.
- Reset mid-grant: reset asserted while grant = 4'b0010 -> all outputs zero after that edge. After reset, with request = 4'b0011, channel 0 wins.
